// File: rtl/ldst_sched.sv
// ldst_sched: command scheduler in front of the register-file load/store
// engine. Load/store descriptors are queued in order, each one is split into
// engine transfers of at most MAX_CHUNK lines, and a single tagged completion
// is reported when the whole descriptor has finished.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   cmd_valid/ready     descriptor handshake (ready = queue not full)
//   cmd_dir             0 = load (SDRAM->RF), 1 = store (RF->SDRAM)
//   cmd_sdram_addr      start SDRAM word address
//   cmd_rf_addr         start RF line
//   cmd_line_num        line count (0 allowed, completes with no transfer)
//   cmd_tag             echoed on completion
//   ldst_start          one-cycle engine start pulse
//   ldst_dir/_sdram_addr/_rf_addr/_line_num  current chunk, stable ISSUE..WAIT_DONE
//   ldst_done           engine chunk-complete pulse (only honoured in WAIT_DONE)
//   cmpl_valid          one-cycle completion pulse with cmpl_tag/cmpl_dir
//   busy                queue non-empty or a descriptor in progress
//
// DEPTH must be a power of two and at least 2.

module ldst_sched #(
  parameter int SDRAM_ADDR_W   = 25,
  parameter int RF_ADDR_W      = 9,
  parameter int DEPTH          = 4,
  parameter int MAX_CHUNK      = 16,
  parameter int WORDS_PER_LINE = 11,
  parameter int TAG_W          = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_dir,
  input  logic [SDRAM_ADDR_W-1:0] cmd_sdram_addr,
  input  logic [RF_ADDR_W-1:0]    cmd_rf_addr,
  input  logic [7:0]              cmd_line_num,
  input  logic [TAG_W-1:0]        cmd_tag,
  output logic                    ldst_start,
  output logic                    ldst_dir,
  output logic [SDRAM_ADDR_W-1:0] ldst_sdram_addr,
  output logic [RF_ADDR_W-1:0]    ldst_rf_addr,
  output logic [7:0]              ldst_line_num,
  input  logic                    ldst_done,
  output logic                    cmpl_valid,
  output logic [TAG_W-1:0]        cmpl_tag,
  output logic                    cmpl_dir,
  output logic                    busy
);

  localparam int              PTR_W       = $clog2(DEPTH);
  localparam logic [PTR_W:0]  FULL_COUNT  = (PTR_W+1)'(DEPTH);
  localparam logic [7:0]      MAX_CHUNK_L = 8'(MAX_CHUNK);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    COMPLETE
  } state_t;

  state_t state, state_next;

  // Command queue storage, one array per descriptor field
  logic                    q_dir   [DEPTH];
  logic [SDRAM_ADDR_W-1:0] q_saddr [DEPTH];
  logic [RF_ADDR_W-1:0]    q_raddr [DEPTH];
  logic [7:0]              q_lines [DEPTH];
  logic [TAG_W-1:0]        q_tag   [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             push, pop;

  // Working registers for the descriptor in progress
  logic [7:0]              rem;
  logic [SDRAM_ADDR_W-1:0] saddr;
  logic [RF_ADDR_W-1:0]    raddr;
  logic                    dir_r;
  logic [TAG_W-1:0]        tag_r;

  logic [7:0]              chunk;
  logic [7:0]              rem_after;
  logic [SDRAM_ADDR_W-1:0] chunk_words;
  logic                    done_hit;

  // Readiness depends only on the current count, so a full queue refuses a
  // push even when the FSM pops in the same cycle.
  assign cmd_ready = (count != FULL_COUNT);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == IDLE) && (count != '0);

  assign chunk       = (rem > MAX_CHUNK_L) ? MAX_CHUNK_L : rem;
  assign rem_after   = rem - chunk;
  assign chunk_words = SDRAM_ADDR_W'(chunk) * SDRAM_ADDR_W'(WORDS_PER_LINE);
  assign done_hit    = (state == WAIT_DONE) && ldst_done;

  // Queue payload needs no reset; only valid entries are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      q_dir[wr_ptr]   <= cmd_dir;
      q_saddr[wr_ptr] <= cmd_sdram_addr;
      q_raddr[wr_ptr] <= cmd_rf_addr;
      q_lines[wr_ptr] <= cmd_line_num;
      q_tag[wr_ptr]   <= cmd_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + (PTR_W+1)'(1);
      else if (!push && pop) count <= count - (PTR_W+1)'(1);
    end
  end

  // Addresses advance by the chunk just finished and wrap at their widths.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem   <= '0;
      saddr <= '0;
      raddr <= '0;
      dir_r <= 1'b0;
      tag_r <= '0;
    end else if (pop) begin
      rem   <= q_lines[rd_ptr];
      saddr <= q_saddr[rd_ptr];
      raddr <= q_raddr[rd_ptr];
      dir_r <= q_dir[rd_ptr];
      tag_r <= q_tag[rd_ptr];
    end else if (done_hit) begin
      rem   <= rem_after;
      saddr <= saddr + chunk_words;
      raddr <= raddr + RF_ADDR_W'(chunk);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    ldst_start = 1'b0;
    cmpl_valid = 1'b0;
    case (state)
      IDLE: begin
        if (pop) state_next = (q_lines[rd_ptr] == 8'd0) ? COMPLETE : ISSUE;
      end
      ISSUE: begin
        ldst_start = 1'b1;
        state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (ldst_done) state_next = (rem_after == 8'd0) ? COMPLETE : ISSUE;
      end
      COMPLETE: begin
        cmpl_valid = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign ldst_dir        = dir_r;
  assign ldst_sdram_addr = saddr;
  assign ldst_rf_addr    = raddr;
  assign ldst_line_num   = chunk;
  assign cmpl_tag        = tag_r;
  assign cmpl_dir        = dir_r;
  assign busy            = (count != '0) || (state != IDLE);

endmodule

// File: tb/tb_ldst_sched.sv
// tb_ldst_sched: self-checking bench for ldst_sched. The bench plays the
// rf_ldst engine (random done latency, optional stall) and keeps a reference
// model: every accepted descriptor is expanded into its expected sequence of
// engine chunks followed by one completion, and the DUT's start/completion
// pulses are matched against that sequence in order.

module tb_ldst_sched;

  localparam int SAW = 25;
  localparam int RAW = 9;
  localparam int TW  = 4;
  localparam int MAXC = 16;
  localparam int WPL  = 11;
  localparam longint SMOD = 64'd1 << SAW;
  localparam int     RMOD = 1 << RAW;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic           cmd_dir = 1'b0;
  logic [SAW-1:0] cmd_sdram_addr = '0;
  logic [RAW-1:0] cmd_rf_addr = '0;
  logic [7:0]     cmd_line_num = '0;
  logic [TW-1:0]  cmd_tag = '0;
  logic           ldst_start;
  logic           ldst_dir;
  logic [SAW-1:0] ldst_sdram_addr;
  logic [RAW-1:0] ldst_rf_addr;
  logic [7:0]     ldst_line_num;
  logic           ldst_done = 1'b0;
  logic           cmpl_valid;
  logic [TW-1:0]  cmpl_tag;
  logic           cmpl_dir;
  logic           busy;

  ldst_sched #(
    .SDRAM_ADDR_W(SAW), .RF_ADDR_W(RAW), .DEPTH(4),
    .MAX_CHUNK(MAXC), .WORDS_PER_LINE(WPL), .TAG_W(TW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_sdram_addr(cmd_sdram_addr), .cmd_rf_addr(cmd_rf_addr),
    .cmd_line_num(cmd_line_num), .cmd_tag(cmd_tag),
    .ldst_start(ldst_start), .ldst_dir(ldst_dir),
    .ldst_sdram_addr(ldst_sdram_addr), .ldst_rf_addr(ldst_rf_addr),
    .ldst_line_num(ldst_line_num), .ldst_done(ldst_done),
    .cmpl_valid(cmpl_valid), .cmpl_tag(cmpl_tag), .cmpl_dir(cmpl_dir),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit     is_cmpl;
    bit     dir;
    longint saddr;
    int     raddr;
    int     lines;
    int     tag;
  } ev_t;

  ev_t ev_q[$];
  ev_t start_log[$];
  int  cmpl_tag_log[$];

  int tests_run = 0;
  int tests_failed = 0;

  int cyc = 0;
  int accept_cyc = 0, start_cyc = 0, cmpl_cyc = 0, done_cyc = 0, last_gap = 0;
  int n_accepted = 0, n_starts = 0, n_cmpl = 0;

  bit  eng_busy = 0;
  bit  eng_hold = 0;
  int  eng_cnt = 0;
  ev_t last_start;

  task automatic check_output(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  // Expand a descriptor into its chunk sequence and completion
  function automatic void push_desc(input bit dir, input longint saddr, input int raddr,
                                    input int lines, input int tag);
    ev_t e;
    longint s = saddr;
    int r = raddr;
    int rem = lines;
    while (rem > 0) begin
      int c = (rem < MAXC) ? rem : MAXC;
      e = '{is_cmpl: 1'b0, dir: dir, saddr: s, raddr: r, lines: c, tag: tag};
      ev_q.push_back(e);
      s = (s + longint'(c) * WPL) % SMOD;
      r = (r + c) % RMOD;
      rem = rem - c;
    end
    e = '{is_cmpl: 1'b1, dir: dir, saddr: 0, raddr: 0, lines: 0, tag: tag};
    ev_q.push_back(e);
  endfunction

  // One clock cycle: drive engine response, record acceptance, then sample
  task automatic tick(output bit acc);
    ev_t e;
    ldst_done = 1'b0;
    if (eng_busy && !eng_hold) begin
      if (eng_cnt == 0) begin
        check_output("hold_sdram", ldst_sdram_addr, last_start.saddr);
        check_output("hold_rf", ldst_rf_addr, last_start.raddr);
        check_output("hold_dir", ldst_dir, last_start.dir);
        ldst_done = 1'b1;
        eng_busy = 0;
        done_cyc = cyc + 1;
      end else begin
        eng_cnt--;
      end
    end
    acc = cmd_valid && cmd_ready;
    if (acc) begin
      push_desc(cmd_dir, longint'(cmd_sdram_addr), int'(cmd_rf_addr), int'(cmd_line_num), int'(cmd_tag));
      accept_cyc = cyc + 1;
      n_accepted++;
    end
    @(posedge clk);
    cyc++;
    #1;
    if (ldst_start) begin
      check_output("start_expected", ev_q.size() != 0, 1);
      if (ev_q.size() != 0) begin
        e = ev_q.pop_front();
        check_output("start_kind", e.is_cmpl, 0);
        check_output("start_sdram", ldst_sdram_addr, e.saddr);
        check_output("start_rf", ldst_rf_addr, e.raddr);
        check_output("start_lines", ldst_line_num, e.lines);
        check_output("start_dir", ldst_dir, e.dir);
      end
      last_start = '{is_cmpl: 1'b0, dir: ldst_dir, saddr: longint'(ldst_sdram_addr),
                     raddr: int'(ldst_rf_addr), lines: int'(ldst_line_num), tag: 0};
      start_log.push_back(last_start);
      last_gap = cyc - cmpl_cyc;
      start_cyc = cyc;
      n_starts++;
      eng_busy = 1;
      eng_cnt = $urandom_range(1, 4);
    end
    if (cmpl_valid) begin
      check_output("cmpl_start_excl", ldst_start, 0);
      check_output("cmpl_expected", ev_q.size() != 0, 1);
      if (ev_q.size() != 0) begin
        e = ev_q.pop_front();
        check_output("cmpl_kind", e.is_cmpl, 1);
        check_output("cmpl_tag", cmpl_tag, e.tag);
        check_output("cmpl_dir", cmpl_dir, e.dir);
      end
      cmpl_tag_log.push_back(int'(cmpl_tag));
      cmpl_cyc = cyc;
      n_cmpl++;
    end
  endtask

  task automatic apply_stimulus(input bit dir, input longint saddr, input int raddr,
                                input int lines, input int tag);
    bit acc = 0;
    int k = 0;
    cmd_dir = dir;
    cmd_sdram_addr = saddr[SAW-1:0];
    cmd_rf_addr = RAW'(raddr);
    cmd_line_num = 8'(lines);
    cmd_tag = TW'(tag);
    cmd_valid = 1'b1;
    while (!acc && k < 500) begin
      tick(acc);
      k++;
    end
    cmd_valid = 1'b0;
    check_output("accept_in_time", acc, 1);
  endtask

  task automatic drain(input int budget);
    bit acc;
    int k = 0;
    while ((ev_q.size() != 0 || busy) && k < budget) begin
      tick(acc);
      k++;
    end
    check_output("drain_queue_empty", ev_q.size(), 0);
    check_output("drain_not_busy", busy, 0);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_output({pfx, "_cmd_ready"}, cmd_ready, 1);
    check_output({pfx, "_ldst_start"}, ldst_start, 0);
    check_output({pfx, "_cmpl_valid"}, cmpl_valid, 0);
    check_output({pfx, "_busy"}, busy, 0);
    check_output({pfx, "_ldst_sdram"}, ldst_sdram_addr, 0);
    check_output({pfx, "_ldst_rf"}, ldst_rf_addr, 0);
    check_output({pfx, "_ldst_lines"}, ldst_line_num, 0);
    check_output({pfx, "_ldst_dir"}, ldst_dir, 0);
    check_output({pfx, "_cmpl_tag"}, cmpl_tag, 0);
    check_output({pfx, "_cmpl_dir"}, cmpl_dir, 0);
  endtask

  initial begin
    bit acc;
    int n0, a0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick(acc);

    // Single load: latency from accept to start, done to completion, busy fall
    apply_stimulus(0, 'h100, 5, 3, 2);
    n0 = n_cmpl;
    for (int k = 0; k < 50 && n_cmpl == n0; k++) tick(acc);
    check_output("single_cmpl_seen", n_cmpl - n0, 1);
    check_output("single_start_latency", start_cyc - accept_cyc, 1);
    check_output("single_done_to_cmpl", cmpl_cyc - done_cyc, 0);
    check_output("single_busy_at_cmpl", busy, 1);
    tick(acc);
    check_output("single_busy_after", busy, 0);

    // Chunking of a 40-line store
    start_log.delete();
    n0 = n_cmpl;
    apply_stimulus(1, 0, 0, 40, 3);
    drain(400);
    check_output("chunk_count", start_log.size(), 3);
    check_output("chunk_cmpl_count", n_cmpl - n0, 1);
    if (start_log.size() == 3) begin
      check_output("chunk0_sdram", start_log[0].saddr, 'h0);
      check_output("chunk1_sdram", start_log[1].saddr, 'hB0);
      check_output("chunk1_rf", start_log[1].raddr, 16);
      check_output("chunk2_sdram", start_log[2].saddr, 'h160);
      check_output("chunk2_rf", start_log[2].raddr, 32);
      check_output("chunk2_lines", start_log[2].lines, 8);
    end

    // Address wrap on both SDRAM and RF addresses
    start_log.delete();
    apply_stimulus(0, 'h1FFFFFA, 510, 20, 4);
    drain(400);
    check_output("wrap_count", start_log.size(), 2);
    if (start_log.size() == 2) begin
      check_output("wrap_sdram", start_log[1].saddr, 'hAA);
      check_output("wrap_rf", start_log[1].raddr, 14);
      check_output("wrap_lines", start_log[1].lines, 4);
    end

    // Minimum gap between consecutive descriptors
    apply_stimulus(0, 'h40, 1, 1, 5);
    apply_stimulus(1, 'h80, 2, 1, 6);
    drain(400);
    check_output("desc_gap", last_gap, 2);

    // Zero-length descriptor
    n0 = n_starts;
    a0 = n_cmpl;
    apply_stimulus(0, 'h55, 3, 0, 7);
    drain(100);
    check_output("zero_no_start", n_starts - n0, 0);
    check_output("zero_cmpl_count", n_cmpl - a0, 1);
    check_output("zero_cmpl_latency", cmpl_cyc - accept_cyc, 1);

    // Backpressure with the engine stalled
    cmpl_tag_log.delete();
    eng_hold = 1;
    for (int t = 0; t < 5; t++) apply_stimulus(t[0], longint'(t) * 'h100, t, 2, t);
    check_output("bp_ready_low", cmd_ready, 0);
    a0 = n_accepted;
    cmd_tag = 4'd5;
    cmd_line_num = 8'd2;
    cmd_valid = 1'b1;
    repeat (3) tick(acc);
    check_output("bp_held", n_accepted - a0, 0);
    eng_hold = 0;
    apply_stimulus(1, 'h500, 5, 2, 5);
    drain(600);
    check_output("bp_cmpl_count", cmpl_tag_log.size(), 6);
    for (int t = 0; t < 6 && t < cmpl_tag_log.size(); t++)
      check_output("bp_cmpl_order", cmpl_tag_log[t], t);

    // Reset in WAIT_DONE with two descriptors queued
    eng_hold = 1;
    apply_stimulus(0, 'h1000, 8, 5, 9);
    apply_stimulus(1, 'h2000, 9, 5, 10);
    apply_stimulus(0, 'h3000, 10, 5, 11);
    repeat (2) tick(acc);
    check_output("rst_pre_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    ev_q.delete();
    eng_busy = 0;
    eng_hold = 0;
    ldst_done = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n0 = n_cmpl;
    repeat (5) tick(acc);
    check_output("midrst_no_cmpl", n_cmpl - n0, 0);
    apply_stimulus(1, 'h4000, 20, 17, 12);
    drain(400);
    check_output("midrst_recover_cmpl", n_cmpl - n0, 1);

    // Randomised descriptors against the reference model
    for (int i = 0; i < 40; i++) begin
      int sel = $urandom_range(0, 9);
      int lines = (sel == 0) ? 0 : (sel == 1) ? 255 : $urandom_range(1, 40);
      longint sa = ($urandom_range(0, 3) == 0) ? (SMOD - longint'($urandom_range(1, 64)))
                                               : longint'($urandom() & 32'h1FFFFFF);
      repeat ($urandom_range(0, 3)) tick(acc);
      apply_stimulus($urandom_range(0, 1), sa, $urandom_range(0, RMOD - 1), lines,
                     $urandom_range(0, 15));
    end
    drain(20000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
